ram_n: RTL and testbench
========================

RAM_N -- requirements
Module: ram_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 3, the address width; depth DEPTH = 2**ADDR_W words.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port wr_en, input, 1: write request for the current cycle.
REQ-006 Port wr_addr, input, ADDR_W: write address.
REQ-007 Port wr_data, input, WIDTH: write data.
REQ-008 Port rd_en, input, 1: read request for the current cycle.
REQ-009 Port rd_addr, input, ADDR_W: read address.
REQ-010 Port rd_data, output, WIDTH: registered read data.
REQ-011 Port rd_valid, output, 1: rd_data updated this cycle.
REQ-012 Port clr_start, input, 1: request a full-memory clear sweep.
REQ-013 Port busy, output, 1: clear sweep in progress.

Function
REQ-014 Storage SHALL be DEPTH independent WIDTH-bit words, written only on a clk edge.
REQ-015 Write: wr_en=1 in IDLE SHALL store wr_data at wr_addr at that edge; no other word changes.
REQ-016 Read: rd_en=1 at edge N SHALL load rd_data with mem[rd_addr] by edge N and assert rd_valid for exactly the following cycle; latency is 1 cycle.
REQ-017 rd_data SHALL hold its last value while rd_en=0; rd_valid SHALL be 0 in that case.
REQ-018 Same-cycle read and write to the same address SHALL be write-first: rd_data receives the new wr_data.
REQ-019 Same-cycle read and write to different addresses SHALL both complete without interaction.
REQ-020 FSM states: IDLE, CLEAR.
REQ-021 IDLE: clr_start=1 SHALL go to CLEAR with sweep counter = 0; busy SHALL rise the following cycle.
REQ-022 CLEAR: each cycle SHALL write 0 to mem[counter] and increment the counter; at counter = DEPTH-1, after that write, the FSM SHALL return to IDLE; the sweep takes exactly DEPTH cycles.
REQ-023 busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-024 In CLEAR, wr_en SHALL be ignored; the write is dropped, not queued.
REQ-025 In CLEAR, reads SHALL be serviced normally; a read of the address being cleared that cycle SHALL return 0 (write-first).
REQ-026 clr_start SHALL be ignored while in CLEAR; there is no restart.
REQ-027 clr_start and wr_en together in IDLE: the write SHALL complete that edge, then the sweep SHALL begin and zero it.
REQ-028 The sweep counter SHALL be ADDR_W bits and SHALL NOT wrap past DEPTH-1 within a sweep.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, clear all memory words to 0, rd_data to 0, rd_valid to 0, busy to 0, counter to 0, and the FSM to IDLE.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep; the memory is all-zero after reset regardless.
REQ-031 The first edge after rst_n deasserts SHALL accept reads and writes normally.

Structure
REQ-032 Shared package ram_pkg SHALL hold the FSM state encoding (IDLE=0, CLEAR=1) and the default WIDTH/ADDR_W constants.
REQ-033 Each word SHALL be one instance of sub-module ram_word: a WIDTH-wide register with load enable and async active-low clear, generated DEPTH times.
REQ-034 Write-address decode and read-data selection SHALL be parametrised logic, not fixed 8-way instances.

Verification
REQ-035 Reset, then write 0xBEEF@3, read @3 next cycle -> rd_data=0xBEEF, rd_valid=1 for one cycle; other addresses read 0x0000.
REQ-036 Same cycle write 0x1234@5 and read @5 -> rd_data=0x1234 one cycle later.
REQ-037 Fill all 8 words with 0x1111..0x8888, pulse clr_start -> busy=1 for exactly 8 cycles; all reads afterwards return 0x0000.
REQ-038 During the sweep, wr_en with 0xAAAA@7 -> dropped; @7 reads 0x0000 after the sweep.
REQ-039 Assert rst_n=0 on sweep cycle 3 between edges -> busy, rd_valid, and rd_data go to 0 immediately; FSM in IDLE; all words read 0x0000.
REQ-040 WIDTH=32, ADDR_W=5: write 0xDEADBEEF@31, read @31 -> 0xDEADBEEF; sweep lasts 32 cycles.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the ram_n memory block:
// default geometry and the sweep FSM state encoding.
package ram_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/ram_word.sv
// One storage word: WIDTH-bit register with load enable.
// Ports: clk, rst_n (async clear), load, d -> q.
module ram_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram_n.sv
// DEPTH x WIDTH register RAM, 1-cycle write-first read,
// plus a DEPTH-cycle clear sweep.
// Ports: clk, rst_n; wr_en/wr_addr/wr_data write port;
// rd_en/rd_addr -> rd_data/rd_valid read port;
// clr_start starts a sweep, busy flags it.
module ram_n
    import ram_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              clr_start,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nx;

    // Effective write for this edge: either the user
    // port (IDLE) or the sweep zeroing mem[cnt] (CLEAR).
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd;

    logic [WIDTH-1:0]  q [DEPTH];
    logic [WIDTH-1:0]  rd_next;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        we       = 1'b0;
        wa       = wr_addr;
        wd       = wr_data;
        unique case (state)
            IDLE: begin
                we = wr_en;
                if (clr_start) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                we = 1'b1;
                wa = cnt;
                wd = '0;
                if (cnt == LAST) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        ram_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (we && (wa == ADDR_W'(i))),
            .d     (wd),
            .q     (q[i])
        );
    end

    // Write-first bypass: a read hitting this edge's
    // write sees the incoming data.
    always_comb begin
        rd_next = q[rd_addr];
        if (we && (wa == rd_addr)) begin
            rd_next = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_next;
            end
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: tb/tb_ram_n.sv
// Randomized + directed bench for ram_n with a
// behavioural memory model and per-cycle comparison.
module tb_ram_n;

    logic        clk;
    logic        rst_n;

    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        clr_start;
    logic        busy;

    logic        b_wr_en;
    logic [4:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_rd_en;
    logic [4:0]  b_rd_addr;
    logic [31:0] b_rd_data;
    logic        b_rd_valid;
    logic        b_clr_start;
    logic        b_busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_mem [8];
    int          m_left;
    logic [15:0] m_rd;
    logic        m_valid;

    ram_n dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .clr_start (clr_start),
        .busy      (busy)
    );

    ram_n #(.WIDTH(32), .ADDR_W(5)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (b_wr_en),
        .wr_addr   (b_wr_addr),
        .wr_data   (b_wr_data),
        .rd_en     (b_rd_en),
        .rd_addr   (b_rd_addr),
        .rd_data   (b_rd_data),
        .rd_valid  (b_rd_valid),
        .clr_start (b_clr_start),
        .busy      (b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
        m_left  = 0;
        m_rd    = 16'h0;
        m_valid = 1'b0;
    endtask

    // What one rising edge does, from the behavioural rules:
    // a running sweep zeroes the next word and swallows
    // user writes / clear requests; reads see this edge's write.
    task automatic model_edge(input logic we, input logic [2:0] wa,
                              input logic [15:0] wd, input logic re,
                              input logic [2:0] ra, input logic cs);
        if (m_left > 0) begin
            m_mem[8 - m_left] = 16'h0;
            m_left--;
        end else begin
            if (we) m_mem[wa] = wd;
            if (cs) m_left = 8;
        end
        if (re) m_rd = m_mem[ra];
        m_valid = re;
    endtask

    task automatic edge_a(input logic we, input logic [2:0] wa,
                          input logic [15:0] wd, input logic re,
                          input logic [2:0] ra, input logic cs);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_en     = re;
        rd_addr   = ra;
        clr_start = cs;
        model_edge(we, wa, wd, re, ra, cs);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic re,
                        input logic [2:0] ra, input logic cs);
        @(negedge clk);
        edge_a(we, wa, wd, re, ra, cs);
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic stepb(input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic re,
                         input logic [4:0] ra, input logic cs);
        @(negedge clk);
        b_wr_en     = we;
        b_wr_addr   = wa;
        b_wr_data   = wd;
        b_rd_en     = re;
        b_rd_addr   = ra;
        b_clr_start = cs;
        edge_a(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
    endtask

    // Per-cycle comparison of the 16-bit DUT against the model.
    always @(posedge clk) begin
        #1;
        chk("cyc rd_data", 64'(rd_data), 64'(m_rd));
        chk("cyc rd_valid", 64'(rd_valid), 64'(m_valid));
        chk("cyc busy", 64'(busy), 64'(m_left > 0));
    end

    initial begin
        int n;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        rd_en = 0; rd_addr = 0; clr_start = 0;
        b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0;
        b_rd_en = 0; b_rd_addr = 0; b_clr_start = 0;
        rst_n = 1'b1;
        model_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_data", 64'(rd_data), 64'h0);
        chk("reset rd_valid", 64'(rd_valid), 64'h0);
        chk("reset busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        edge_a(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 1'b0);

        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0);
        chk("read @3", 64'(rd_data), 64'hBEEF);
        chk("read @3 valid", 64'(rd_valid), 64'h1);
        idle();
        chk("valid one cycle", 64'(rd_valid), 64'h0);
        chk("rd_data holds", 64'(rd_data), 64'hBEEF);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0);
        chk("read @2 empty", 64'(rd_data), 64'h0);

        step(1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 1'b0);
        chk("write-first @5", 64'(rd_data), 64'h1234);
        step(1'b1, 3'd1, 16'h4321, 1'b1, 3'd3, 1'b0);
        chk("rd/wr diff addr", 64'(rd_data), 64'hBEEF);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b0);
        chk("read @1", 64'(rd_data), 64'h4321);

        for (int i = 0; i < 8; i++)
            step(1'b1, 3'(i), 16'((i + 1) * 16'h1111), 1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 1'b0);
        chk("fill @7", 64'(rd_data), 64'h8888);
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            idle();
        end
        chk("sweep length", 64'(n), 64'd8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b0);
            chk("after sweep", 64'(rd_data), 64'h0);
        end

        step(1'b1, 3'd7, 16'h9999, 1'b1, 3'd7, 1'b1);
        chk("wr+clr write lands", 64'(rd_data), 64'h9999);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step(1'b1, 3'd7, 16'hAAAA, 1'b0, 3'd0, 1'b1);
        end
        chk("sweep length 2", 64'(n), 64'd8);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 1'b0);
        chk("dropped write @7", 64'(rd_data), 64'h0);

        step(1'b1, 3'd6, 16'h5555, 1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1);
        idle();
        idle();
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b0);
        chk("sweep read @6", 64'(rd_data), 64'h5555);
        chk("sweep busy", 64'(busy), 64'h1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async rst busy", 64'(busy), 64'h0);
        chk("async rst valid", 64'(rd_valid), 64'h0);
        chk("async rst data", 64'(rd_data), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        edge_a(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b0);
        chk("post-rst @6", 64'(rd_data), 64'h0);
        chk("post-rst idle", 64'(busy), 64'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b0);
            chk("post-rst zero", 64'(rd_data), 64'h0);
        end

        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 16'($urandom), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 39) == 0));
        end
        n = 0;
        while (busy && n < 100) begin
            n++;
            idle();
        end

        stepb(1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        stepb(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b0);
        chk("b read @31", 64'(b_rd_data), 64'hDEADBEEF);
        chk("b valid", 64'(b_rd_valid), 64'h1);
        stepb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        n = 0;
        while (b_busy && n < 200) begin
            n++;
            stepb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        end
        chk("b sweep length", 64'(n), 64'd32);
        stepb(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b0);
        chk("b @31 cleared", 64'(b_rd_data), 64'h0);
        stepb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
